// File: rtl/tsp_pkg.sv
// Shared types, FSM state codes and swap edge tables for the TSP swap evaluator.
// Point indices are 0-based: index 0 is vertex 1.
package tsp_pkg;

  typedef logic [7:0] coord_t;
  typedef logic [2:0] state_t;
  typedef logic [2:0] pt_idx_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SQRT = 3'd2;
  localparam state_t ST_ACC  = 3'd3;
  localparam state_t ST_CMP  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  // Mode 0 old tour d12,d23,d45,d56 then new tour d15,d53,d42,d26
  localparam pt_idx_t EDGE_A_M0 [8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0, 3'd4, 3'd3, 3'd1};
  localparam pt_idx_t EDGE_B_M0 [8] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd4, 3'd2, 3'd1, 3'd5};
  localparam logic [7:0] EDGE_OLD_M0 = 8'b0000_1111;

  // Mode 1 old tour d12,d34 then new tour d13,d24
  localparam pt_idx_t EDGE_A_M1 [4] = '{3'd0, 3'd2, 3'd0, 3'd1};
  localparam pt_idx_t EDGE_B_M1 [4] = '{3'd1, 3'd3, 3'd2, 3'd3};
  localparam logic [3:0] EDGE_OLD_M1 = 4'b0011;

  function automatic int root_w(input int frac);
    return 9 + frac;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one result bit per clock.
// Root is valid ROOT_W cycles after the start cycle and holds until the next start.
module isqrt_seq #(
  parameter int ROOT_W = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [2*ROOT_W-1:0] i_radicand,
  output logic [ROOT_W-1:0]   o_root,
  output logic                o_valid
);

  localparam int RAD_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 2;
  localparam int CNT_W = $clog2(ROOT_W + 1);

  logic [RAD_W-1:0]  r_rad;
  logic [REM_W-1:0]  r_rem;
  logic [ROOT_W-1:0] r_root;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;

  logic [REM_W-1:0]  w_rem_sh;
  logic [REM_W-1:0]  w_trial;
  logic              w_fits;

  // Bring down the next radicand bit pair and try appending a 1 to the root
  assign w_rem_sh = {r_rem[REM_W-3:0], r_rad[RAD_W-1 -: 2]};
  assign w_trial  = {r_root, 2'b01};
  assign w_fits   = (w_rem_sh >= w_trial);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_rad   <= i_radicand;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= CNT_W'(ROOT_W);
      r_valid <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
      r_root <= {r_root[ROOT_W-2:0], w_fits};
      r_cnt  <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_root  = r_root;
  assign o_valid = r_valid;

endmodule

// File: rtl/tour_swap_evaluator.sv
// Swap-check responder: sums old and new tour edge lengths through one shared
// sequential distance unit and reports whether the proposed swap shortens the tour.
module tour_swap_evaluator
  import tsp_pkg::*;
#(
  parameter int FRAC_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_mode,
  input  coord_t      i_x1,
  input  coord_t      i_x2,
  input  coord_t      i_x3,
  input  coord_t      i_x4,
  input  coord_t      i_x5,
  input  coord_t      i_x6,
  input  coord_t      i_y1,
  input  coord_t      i_y2,
  input  coord_t      i_y3,
  input  coord_t      i_y4,
  input  coord_t      i_y5,
  input  coord_t      i_y6,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_should_swap,
  output logic [31:0] o_difference
);

  localparam int ROOT_W = root_w(FRAC_BITS);
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int CNT_W  = $clog2(ROOT_W);

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  coord_t            r_x [6];
  coord_t            r_y [6];
  logic [2:0]        r_edge;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [31:0]       r_old_sum;
  logic [31:0]       r_new_sum;
  logic              r_should_swap;
  logic [31:0]       r_difference;

  logic              w_accept;
  logic              w_last_edge;
  logic              w_is_old;
  pt_idx_t           w_pa;
  pt_idx_t           w_pb;
  coord_t            w_ax;
  coord_t            w_ay;
  coord_t            w_bx;
  coord_t            w_by;
  coord_t            w_dx;
  coord_t            w_dy;
  logic [16:0]       w_d2;
  logic [RAD_W-1:0]  w_radicand;
  logic              w_sqrt_start;
  logic [ROOT_W-1:0] w_root;
  logic              w_root_valid;

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;

  always_comb begin
    w_pa        = EDGE_A_M0[r_edge];
    w_pb        = EDGE_B_M0[r_edge];
    w_is_old    = EDGE_OLD_M0[r_edge];
    w_last_edge = (r_edge == 3'd7);
    if (r_mode) begin
      w_pa        = EDGE_A_M1[r_edge[1:0]];
      w_pb        = EDGE_B_M1[r_edge[1:0]];
      w_is_old    = EDGE_OLD_M1[r_edge[1:0]];
      w_last_edge = (r_edge == 3'd3);
    end
  end

  // Squared edge length in fixed point: scaling d2 by 4^FRAC gives FRAC root fraction bits
  assign w_ax       = r_x[w_pa];
  assign w_ay       = r_y[w_pa];
  assign w_bx       = r_x[w_pb];
  assign w_by       = r_y[w_pb];
  assign w_dx       = (w_ax >= w_bx) ? (w_ax - w_bx) : (w_bx - w_ax);
  assign w_dy       = (w_ay >= w_by) ? (w_ay - w_by) : (w_by - w_ay);
  assign w_d2       = 17'(w_dx) * 17'(w_dx) + 17'(w_dy) * 17'(w_dy);
  assign w_radicand = RAD_W'(w_d2) << (2 * FRAC_BITS);
  assign w_sqrt_start = (r_state == ST_LOAD);

  isqrt_seq #(
    .ROOT_W(ROOT_W)
  ) u_isqrt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_sqrt_start),
    .i_radicand (w_radicand),
    .o_root     (w_root),
    .o_valid    (w_root_valid)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_SQRT;
      ST_SQRT: if (r_bit_cnt == CNT_W'(ROOT_W - 1)) w_next = ST_ACC;
      ST_ACC:  w_next = w_last_edge ? ST_CMP : ST_LOAD;
      ST_CMP:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (i_abort) begin
      w_next = ST_IDLE;
    end
  end

  // Abort suppresses all datapath updates so a cancelled run leaves outputs cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_mode        <= 1'b0;
      r_edge        <= '0;
      r_bit_cnt     <= '0;
      r_old_sum     <= '0;
      r_new_sum     <= '0;
      r_should_swap <= 1'b0;
      r_difference  <= '0;
      for (int k = 0; k < 6; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode        <= i_mode;
        r_x[0] <= i_x1;  r_x[1] <= i_x2;  r_x[2] <= i_x3;
        r_x[3] <= i_x4;  r_x[4] <= i_x5;  r_x[5] <= i_x6;
        r_y[0] <= i_y1;  r_y[1] <= i_y2;  r_y[2] <= i_y3;
        r_y[3] <= i_y4;  r_y[4] <= i_y5;  r_y[5] <= i_y6;
        r_edge        <= '0;
        r_old_sum     <= '0;
        r_new_sum     <= '0;
        r_should_swap <= 1'b0;
        r_difference  <= '0;
      end
      if (!i_abort) begin
        case (r_state)
          ST_LOAD: r_bit_cnt <= '0;
          ST_SQRT: r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          ST_ACC: begin
            if (w_root_valid) begin
              if (w_is_old) r_old_sum <= r_old_sum + 32'(w_root);
              else          r_new_sum <= r_new_sum + 32'(w_root);
            end
            r_edge <= r_edge + 3'd1;
          end
          ST_CMP: begin
            if (r_new_sum < r_old_sum) begin
              r_should_swap <= 1'b1;
              r_difference  <= r_old_sum - r_new_sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_should_swap = r_should_swap;
  assign o_difference  = r_difference;

endmodule

// File: tb/tb_tour_swap_evaluator.sv
// Self-checking bench for tour_swap_evaluator: spec vectors, handshake corner cases,
// and random requests checked against a geometric reference model.
module tb_tour_swap_evaluator;

  localparam int FRAC   = 4;
  localparam int ROOTW  = 9 + FRAC;
  localparam int LAT_M0 = 8 * (ROOTW + 2) + 2;
  localparam int LAT_M1 = 4 * (ROOTW + 2) + 2;

  typedef logic [5:0][7:0] pts_t;

  typedef struct {
    logic        mode;
    pts_t        xs;
    pts_t        ys;
    logic        expSwap;
    logic [31:0] expDiff;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic        iMode = 1'b0;
  logic [7:0]  iX1 = '0, iX2 = '0, iX3 = '0, iX4 = '0, iX5 = '0, iX6 = '0;
  logic [7:0]  iY1 = '0, iY2 = '0, iY3 = '0, iY4 = '0, iY5 = '0, iY6 = '0;
  logic        oBusy;
  logic        oDone;
  logic        oShouldSwap;
  logic [31:0] oDifference;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  tour_swap_evaluator #(.FRAC_BITS(FRAC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (iStart),
    .i_abort       (iAbort),
    .i_mode        (iMode),
    .i_x1          (iX1),
    .i_x2          (iX2),
    .i_x3          (iX3),
    .i_x4          (iX4),
    .i_x5          (iX5),
    .i_x6          (iX6),
    .i_y1          (iY1),
    .i_y2          (iY2),
    .i_y3          (iY3),
    .i_y4          (iY4),
    .i_y5          (iY5),
    .i_y6          (iY6),
    .o_busy        (oBusy),
    .o_done        (oDone),
    .o_should_swap (oShouldSwap),
    .o_difference  (oDifference)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic pts_t mkPts(input int p1, p2, p3, p4, p5, p6);
    pts_t r;
    r[0] = 8'(p1); r[1] = 8'(p2); r[2] = 8'(p3);
    r[3] = 8'(p4); r[4] = 8'(p5); r[5] = 8'(p6);
    return r;
  endfunction

  // Reference edge length: floor(sqrt(d2) * 2^FRAC) == isqrt(d2 * 4^FRAC)
  function automatic longint edgeLen(input int ax, ay, bx, by);
    longint n;
    longint r;
    n = longint'((ax - bx) * (ax - bx) + (ay - by) * (ay - by)) * longint'(1 << (2 * FRAC));
    r = longint'($rtoi($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic longint lenP(input pts_t xs, input pts_t ys, input int a, input int b);
    return edgeLen(int'(xs[a-1]), int'(ys[a-1]), int'(xs[b-1]), int'(ys[b-1]));
  endfunction

  function automatic void modelSwap(input logic mode, input pts_t xs, input pts_t ys,
                                    output logic swap, output logic [31:0] diff);
    longint oldLen;
    longint newLen;
    if (mode) begin
      oldLen = lenP(xs, ys, 1, 2) + lenP(xs, ys, 3, 4);
      newLen = lenP(xs, ys, 1, 3) + lenP(xs, ys, 2, 4);
    end else begin
      oldLen = lenP(xs, ys, 1, 2) + lenP(xs, ys, 2, 3) + lenP(xs, ys, 4, 5) + lenP(xs, ys, 5, 6);
      newLen = lenP(xs, ys, 1, 5) + lenP(xs, ys, 5, 3) + lenP(xs, ys, 4, 2) + lenP(xs, ys, 2, 6);
    end
    swap = (newLen < oldLen);
    diff = swap ? 32'(oldLen - newLen) : 32'd0;
  endfunction

  task automatic setInputs(input logic mode, input pts_t xs, input pts_t ys);
    iMode = mode;
    iX1 = xs[0]; iX2 = xs[1]; iX3 = xs[2]; iX4 = xs[3]; iX5 = xs[4]; iX6 = xs[5];
    iY1 = ys[0]; iY2 = ys[1]; iY3 = ys[2]; iY4 = ys[3]; iY5 = ys[4]; iY6 = ys[5];
  endtask

  // Leaves the bench at the falling edge of the first cycle after the accepting edge
  task automatic applyStimulus(input logic mode, input pts_t xs, input pts_t ys);
    @(negedge clk);
    setInputs(mode, xs, ys);
    iStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    checkOutput("acceptBusy", 32'(oBusy), 32'd1);
    checkOutput("acceptClearSwap", 32'(oShouldSwap), 32'd0);
    checkOutput("acceptClearDiff", oDifference, 32'd0);
  endtask

  // Latency counts clock edges from the accepting edge to the edge that samples done high
  task automatic waitDone(output int lat);
    int cyc;
    bit found;
    cyc = 0;
    found = 1'b0;
    lat = -1;
    while (!found && cyc <= 300) begin
      if (oDone === 1'b1) found = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    if (found) lat = cyc + 1;
    else begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL doneTimeout: got no done, expected done within 300 cycles");
    end
  endtask

  task automatic runVector(input string name, input logic mode, input pts_t xs, input pts_t ys,
                           input logic expSwap, input logic [31:0] expDiff);
    int lat;
    applyStimulus(mode, xs, ys);
    waitDone(lat);
    checkOutput({name, "_latency"}, 32'(lat), mode ? 32'(LAT_M1) : 32'(LAT_M0));
    checkOutput({name, "_swap"}, 32'(oShouldSwap), 32'(expSwap));
    checkOutput({name, "_diff"}, oDifference, expDiff);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_idleBusy"}, 32'(oBusy), 32'd0);
    checkOutput({name, "_holdSwap"}, 32'(oShouldSwap), 32'(expSwap));
    checkOutput({name, "_holdDiff"}, oDifference, expDiff);
  endtask

  task automatic expectNoDone(input string name, input int cycles);
    logic sawDone;
    sawDone = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (oDone !== 1'b0) sawDone = 1'b1;
    end
    checkOutput(name, 32'(sawDone), 32'd0);
  endtask

  // Protocol watchers: one-cycle done, done inside busy, results frozen while idle
  logic        monOn = 1'b0;
  logic        prevValid = 1'b0;
  logic        prevBusy = 1'b0;
  logic        prevDone = 1'b0;
  logic        prevSwap = 1'b0;
  logic [31:0] prevDiff = '0;

  always @(negedge clk) begin
    if (monOn && rst_n === 1'b1 && prevValid) begin
      if (prevDone) checkOutput("donePulseWidth", 32'(oDone), 32'd0);
      if (oDone === 1'b1) checkOutput("doneWithinBusy", 32'(oBusy), 32'd1);
      if (!prevBusy && oBusy === 1'b0) begin
        checkOutput("idleStableSwap", 32'(oShouldSwap), 32'(prevSwap));
        checkOutput("idleStableDiff", oDifference, prevDiff);
      end
    end
    prevValid = (rst_n === 1'b1);
    prevBusy  = oBusy;
    prevDone  = oDone;
    prevSwap  = oShouldSwap;
    prevDiff  = oDifference;
  end

  vec_t tbl [5];

  initial begin
    int lat;
    int cyc;
    bit found;
    logic mSwap;
    logic [31:0] mDiff;
    logic rMode;
    pts_t rx;
    pts_t ry;
    int span;

    tbl[0] = '{1'b1, mkPts(0, 10, 10, 0, 0, 0), mkPts(0, 10, 0, 10, 0, 0), 1'b1, 32'd132};
    tbl[1] = '{1'b0, mkPts(0, 10, 20, 100, 110, 120), mkPts(0, 0, 0, 0, 0, 0), 1'b0, 32'd0};
    tbl[2] = '{1'b0, mkPts(0, 110, 20, 100, 10, 120), mkPts(0, 0, 0, 0, 0, 0), 1'b1, 32'd5760};
    tbl[3] = '{1'b1, mkPts(0, 255, 0, 255, 0, 0), mkPts(0, 255, 0, 255, 0, 0), 1'b1, 32'd11538};
    tbl[4] = '{1'b0, mkPts(7, 7, 7, 7, 7, 7), mkPts(7, 7, 7, 7, 7, 7), 1'b0, 32'd0};

    #12;
    checkOutput("resetBusy", 32'(oBusy), 32'd0);
    checkOutput("resetDone", 32'(oDone), 32'd0);
    checkOutput("resetSwap", 32'(oShouldSwap), 32'd0);
    checkOutput("resetDiff", oDifference, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    monOn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      runVector($sformatf("table%0d", i), tbl[i].mode, tbl[i].xs, tbl[i].ys,
                tbl[i].expSwap, tbl[i].expDiff);
    end

    // Extra starts mid-run are ignored; a start held over the done cycle is taken one cycle later
    applyStimulus(tbl[2].mode, tbl[2].xs, tbl[2].ys);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc <= 300) begin
      if (oDone === 1'b1) found = 1'b1;
      else begin
        iStart = (cyc == 5 || cyc == 40);
        if (cyc == 5) setInputs(tbl[3].mode, tbl[3].xs, tbl[3].ys);
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    iStart = 1'b0;
    checkOutput("ignoreStart_latency", 32'(found ? cyc + 1 : -1), 32'(LAT_M0));
    checkOutput("ignoreStart_swap", 32'(oShouldSwap), 32'd1);
    checkOutput("ignoreStart_diff", oDifference, 32'd5760);
    setInputs(tbl[0].mode, tbl[0].xs, tbl[0].ys);
    iStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("afterDoneIdle", 32'(oBusy), 32'd0);
    checkOutput("afterDoneHoldDiff", oDifference, 32'd5760);
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    checkOutput("backToBackBusy", 32'(oBusy), 32'd1);
    checkOutput("backToBackClearSwap", 32'(oShouldSwap), 32'd0);
    checkOutput("backToBackClearDiff", oDifference, 32'd0);
    waitDone(lat);
    checkOutput("backToBack_latency", 32'(lat), 32'(LAT_M1));
    checkOutput("backToBack_diff", oDifference, 32'd132);

    // Abort at cycle 30
    applyStimulus(tbl[2].mode, tbl[2].xs, tbl[2].ys);
    repeat (29) @(negedge clk);
    iAbort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iAbort = 1'b0;
    checkOutput("abortBusy", 32'(oBusy), 32'd0);
    checkOutput("abortSwap", 32'(oShouldSwap), 32'd0);
    checkOutput("abortDiff", oDifference, 32'd0);
    expectNoDone("abortNoDone", 140);
    runVector("afterAbort", tbl[0].mode, tbl[0].xs, tbl[0].ys, 1'b1, 32'd132);

    // Abort beats start in the same idle cycle
    @(negedge clk);
    setInputs(tbl[2].mode, tbl[2].xs, tbl[2].ys);
    iStart = 1'b1;
    iAbort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    iAbort = 1'b0;
    checkOutput("abortWithStartBusy", 32'(oBusy), 32'd0);
    expectNoDone("abortWithStartNoDone", 10);

    // Reset at cycle 50
    applyStimulus(tbl[2].mode, tbl[2].xs, tbl[2].ys);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", 32'(oBusy), 32'd0);
    checkOutput("midResetDone", 32'(oDone), 32'd0);
    checkOutput("midResetSwap", 32'(oShouldSwap), 32'd0);
    checkOutput("midResetDiff", oDifference, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    expectNoDone("midResetNoDone", 140);
    runVector("afterReset", tbl[2].mode, tbl[2].xs, tbl[2].ys, 1'b1, 32'd5760);

    // Random requests; narrow coordinate spans make ties and near-ties likely
    for (int i = 0; i < 20; i++) begin
      rMode = 1'($urandom_range(0, 1));
      span = (i % 3 == 0) ? 3 : 255;
      for (int k = 0; k < 6; k++) begin
        rx[k] = 8'($urandom_range(0, span));
        ry[k] = 8'($urandom_range(0, span));
      end
      modelSwap(rMode, rx, ry, mSwap, mDiff);
      runVector($sformatf("random%0d", i), rMode, rx, ry, mSwap, mDiff);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
